uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8-bit, parity-always receiver in the serial/debug path. Adds:
- configurable data width, parity mode and stop-bit count
- 3-sample majority voting at mid-bit
- frame-error and break detection
- a one-entry output holding register with valid/ready handshake and overrun reporting

It sits between the board UART pin and the command/loopback logic in the SDRAM test designs.

---
 rtl/uart_rx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority vote,
// parity/frame/break detection and a one-entry valid/ready holding register.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned UART_RATE   = 1_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 2,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 overrun_o,
  output logic                 break_o
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / UART_RATE;
  localparam int unsigned MID        = BIT_CYCLES / 2;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam int unsigned BW         = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_VOTE = CW'(MID - 1);
  localparam logic          HAS_PAR  = 1'(PARITY_MODE != 0);
  localparam logic          ODD_PAR  = 1'(PARITY_MODE == 1);
  localparam logic          LAST_STP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_pbit;
  logic                 r_stop_cnt;
  logic                 r_stop0;
  logic                 r_ferr;

  logic w_rxs, w_vote_now, w_vote, w_cnt_zero;
  logic w_last_stop, w_first_stop, w_ferr, w_break, w_perr, w_load;

  assign w_rxs        = r_sync2;
  assign w_vote_now   = (r_cnt == CNT_VOTE);
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_vote       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_last_stop  = (r_state == ST_STOP) && w_vote_now && (r_stop_cnt == LAST_STP);
  assign w_first_stop = (r_stop_cnt == 1'b0) ? w_vote : r_stop0;
  assign w_ferr       = r_ferr | ~w_vote;
  assign w_break      = (r_shift == '0) && !(HAS_PAR && r_pbit) && !w_first_stop;
  assign w_perr       = HAS_PAR & ((^r_shift) ^ r_pbit ^ ODD_PAR);
  assign w_load       = w_last_stop && !w_break && (!data_valid_o || data_ready_i);

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: bit timer, mid-bit samples, data shift, parity and stop tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_pbit     <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_stop0    <= 1'b1;
      r_ferr     <= 1'b0;
    end else begin
      if (r_state != ST_IDLE && r_state != ST_WAIT_HIGH) begin
        r_cnt <= w_cnt_zero ? CNT_LOAD : r_cnt - CW'(1);
        if (r_cnt == CNT_S0) r_s0 <= w_rxs;
        if (r_cnt == CNT_S1) r_s1 <= w_rxs;
      end
      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state <= ST_START;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_START: begin
          if (w_vote_now && w_vote) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_zero) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_vote_now) begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          if (w_cnt_zero && r_bit_cnt == BW'(DATA_BITS)) begin
            r_state    <= HAS_PAR ? ST_PARITY : ST_STOP;
            r_stop_cnt <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        ST_PARITY: begin
          if (w_vote_now) r_pbit <= w_vote;
          if (w_cnt_zero) begin
            r_state    <= ST_STOP;
            r_stop_cnt <= 1'b0;
            r_ferr     <= 1'b0;
          end
        end
        ST_STOP: begin
          if (w_vote_now) begin
            if (r_stop_cnt == 1'b0) r_stop0 <= w_vote;
            r_ferr <= w_ferr;
            if (w_last_stop) begin
              r_state <= (w_break || w_ferr) ? ST_WAIT_HIGH : ST_IDLE;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding register with valid/ready handshake plus overrun and break pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      overrun_o      <= 1'b0;
      break_o        <= 1'b0;
    end else begin
      overrun_o <= w_last_stop && !w_break && data_valid_o && !data_ready_i;
      break_o   <= w_last_stop && w_break;
      if (w_load) begin
        data_o         <= r_shift;
        parity_error_o <= w_perr;
        frame_error_o  <= w_ferr;
        data_valid_o   <= 1'b1;
      end else if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: one instance with 8 data bits / even parity /
// 1 stop, one with 9 data bits / no parity / 2 stops, both at 16 cycles per bit.
module tb_uart_rx_cfg;

  localparam int unsigned CLKF = 16_000_000;
  localparam int unsigned RATE = 1_000_000;
  localparam int          BC   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, line_a, ready_a;
  logic [7:0] data_a;
  logic       valid_a, perr_a, ferr_a, ovr_a, brk_a;

  logic       rst_n_b, line_b, ready_b;
  logic [8:0] data_b;
  logic       valid_b, perr_b, ferr_b, ovr_b, brk_b;

  uart_rx_cfg #(.CLK_FREQ(CLKF), .UART_RATE(RATE), .DATA_BITS(8),
                .PARITY_MODE(2), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n_a), .uart_rxd(line_a),
    .data_o(data_a), .data_valid_o(valid_a), .data_ready_i(ready_a),
    .parity_error_o(perr_a), .frame_error_o(ferr_a),
    .overrun_o(ovr_a), .break_o(brk_a));

  uart_rx_cfg #(.CLK_FREQ(CLKF), .UART_RATE(RATE), .DATA_BITS(9),
                .PARITY_MODE(0), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n_b), .uart_rxd(line_b),
    .data_o(data_b), .data_valid_o(valid_b), .data_ready_i(ready_b),
    .parity_error_o(perr_b), .frame_error_o(ferr_b),
    .overrun_o(ovr_b), .break_o(brk_b));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_vec = 0;
  int n_err = 0;
  int n_valid_a = 0, n_ovr_a = 0, n_brk_a = 0;
  int n_ovr_b = 0, n_brk_b = 0;

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    return e;
  endfunction

  // start bit at index 0, then data LSB first, parity, stop
  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic p, input logic s);
    return 16'({s, p, d, 1'b0});
  endfunction

  function automatic logic [15:0] frame_b(input logic [8:0] d);
    return 16'({2'b11, d, 1'b0});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: count pulses and compare every accepted word.
  task automatic monitor();
    exp_t e;
    if (valid_a === 1'b1) n_valid_a++;
    if (ovr_a === 1'b1) n_ovr_a++;
    if (brk_a === 1'b1) n_brk_a++;
    if (ovr_b === 1'b1) n_ovr_b++;
    if (brk_b === 1'b1) n_brk_b++;
    if (valid_a === 1'b1 && ready_a === 1'b1) begin
      n_vec++;
      assert (q_a.size() != 0) else begin
        n_err++;
        $error("FAIL a_unexpected_word: observed %0h expected no word", data_a);
      end
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_word", 32'({data_a, perr_a, ferr_a}), 32'({e.data[7:0], e.perr, e.ferr}));
      end
    end
    if (valid_b === 1'b1 && ready_b === 1'b1) begin
      n_vec++;
      assert (q_b.size() != 0) else begin
        n_err++;
        $error("FAIL b_unexpected_word: observed %0h expected no word", data_b);
      end
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_word", 32'({data_b, perr_b, ferr_b}), 32'({e.data, e.perr, e.ferr}));
      end
    end
  endtask

  // Monitor at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) line_a = v;
    else line_b = v;
  endtask

  // Drive nbits bit periods; optional one-cycle inversion at mid-bit of bit 'glitch'.
  task automatic tx(input int inst, input logic [15:0] bits, input int nbits, input int glitch);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < BC; c++) begin
        tick();
        set_line(inst, bits[i] ^ ((i == glitch) && (c == 8)));
      end
    end
  endtask

  initial begin
    int v0, o0, b0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    line_a  = 1'b1; line_b  = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    idle(3);
    check("a_reset_outputs", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a, brk_a}), 32'd0);
    check("b_reset_outputs", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b, brk_b}), 32'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    idle(8);

    // good frame, valid for exactly one cycle with ready tied high
    v0 = n_valid_a;
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
    tx(0, frame_a(8'hA5, 1'b0, 1'b1), 11, -1);
    idle(BC);
    check("a_valid_one_cycle", 32'(n_valid_a - v0), 32'd1);

    // wrong parity bit
    q_a.push_back(mk(9'h0A5, 1'b1, 1'b0));
    tx(0, frame_a(8'hA5, 1'b1, 1'b1), 11, -1);
    idle(BC);
    check("a_parity_drained", 32'(q_a.size()), 32'd0);

    // short low pulse is a false start
    v0 = n_valid_a; o0 = n_ovr_a; b0 = n_brk_a;
    repeat (4) begin tick(); line_a = 1'b0; end
    tick(); line_a = 1'b1;
    idle(3 * BC);
    check("a_false_start_valid", 32'(n_valid_a - v0), 32'd0);
    check("a_false_start_flags", 32'((n_ovr_a - o0) + (n_brk_a - b0)), 32'd0);

    // glitch at mid-bit of data bit 2 is voted out
    q_a.push_back(mk(9'h00F, 1'b0, 1'b0));
    tx(0, frame_a(8'h0F, 1'b0, 1'b1), 11, 3);
    idle(BC);
    check("a_glitch_drained", 32'(q_a.size()), 32'd0);

    // stop bit low -> frame error
    q_a.push_back(mk(9'h03C, 1'b0, 1'b1));
    tx(0, frame_a(8'h3C, 1'b0, 1'b0), 11, -1);
    tick(); line_a = 1'b1;
    idle(2 * BC);
    check("a_ferr_drained", 32'(q_a.size()), 32'd0);

    // break: all-zero frame, line held low for 30 bit times
    v0 = n_valid_a; b0 = n_brk_a;
    tx(0, frame_a(8'h00, 1'b0, 1'b0), 11, -1);
    idle(30 * BC);
    check("a_break_no_frame_while_low", 32'(n_valid_a - v0), 32'd0);
    tick(); line_a = 1'b1;
    idle(3 * BC);
    check("a_break_pulses", 32'(n_brk_a - b0), 32'd1);
    check("a_break_no_valid", 32'(n_valid_a - v0), 32'd0);

    // overrun: second frame dropped while the first is held
    ready_a = 1'b0;
    o0 = n_ovr_a;
    q_a.push_back(mk(9'h011, 1'b0, 1'b0));
    tx(0, frame_a(8'h11, 1'b0, 1'b1), 11, -1);
    idle(BC);
    tx(0, frame_a(8'h22, 1'b0, 1'b1), 11, -1);
    idle(BC);
    check("a_overrun_pulses", 32'(n_ovr_a - o0), 32'd1);
    check("a_held_word", 32'(data_a), 32'h11);
    check("a_held_valid", 32'(valid_a), 32'd1);
    ready_a = 1'b1;
    idle(4);
    check("a_overrun_drained", 32'(q_a.size()), 32'd0);
    check("a_valid_dropped", 32'(valid_a), 32'd0);

    // 9 data bits, no parity, two stop bits
    q_b.push_back(mk(9'h1FF, 1'b0, 1'b0));
    tx(1, frame_b(9'h1FF), 12, -1);
    idle(BC);
    check("b_1ff_drained", 32'(q_b.size()), 32'd0);

    // hold a word, then reset in the middle of the next frame
    ready_b = 1'b0;
    tx(1, frame_b(9'h123), 12, -1);
    idle(BC);
    check("b_held_word", 32'({valid_b, data_b}), 32'h323);
    tx(1, frame_b(9'h0AA), 5, -1);
    line_b  = 1'b1;
    rst_n_b = 1'b0;
    tick();
    check("b_midframe_reset", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b, brk_b}), 32'd0);
    rst_n_b = 1'b1;
    ready_b = 1'b1;
    idle(2 * BC);
    q_b.push_back(mk(9'h155, 1'b0, 1'b0));
    tx(1, frame_b(9'h155), 12, -1);
    idle(BC);
    check("b_155_drained", 32'(q_b.size()), 32'd0);
    check("b_no_pulses", 32'(n_ovr_b + n_brk_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
